// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchronizer, per-bit debounce counter, stable level and rise/fall pulses.
// Define SW_DEBOUNCE_BYPASS_EN to drop the counters and pass the synchronized level straight through.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // Handshake: none; pulses are single-cycle strobes aligned with the sw_stable update.
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef SW_DEBOUNCE_BYPASS_EN
    // Any difference is taken on the next edge; no filtering at all.
    assign accept = sync2_q ^ stable_q;
`else
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Counter restarts whenever the synchronized level matches the accepted one.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    always_comb begin
        stable_d  = stable_q ^ accept;
        rise_d    = accept & sync2_q;
        fall_d    = accept & ~sync2_q;
        changed_d = |accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_stable  = stable_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=8, CNT_W=4, WIDTH=4.
// Expectations switch to pass-through timing when SW_DEBOUNCE_BYPASS_EN is defined.
module tb_sw_debounce;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;
`ifdef SW_DEBOUNCE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = DEB + 1;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    int checks;
    int failures;

    sw_debounce #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watches edges with no expected activity; true if anything moved.
    task automatic watch_quiet(input int n, input logic [WIDTH-1:0] stable_exp, output bit moved);
        moved = 1'b0;
        for (int e = 0; e < n; e++) begin
            step();
            if (sw_stable !== stable_exp || sw_rise !== '0 || sw_fall !== '0 || sw_changed !== 1'b0)
                moved = 1'b1;
        end
    endtask

    // Called just after an edge on which sw_raw was changed; the next edge is capture edge 0.
    task automatic expect_accept(input string tag, input logic [WIDTH-1:0] prev,
                                 input logic [WIDTH-1:0] nxt, input logic [WIDTH-1:0] rise,
                                 input logic [WIDTH-1:0] fall);
        bit moved;
        watch_quiet(LAT, prev, moved);
        check_eq({tag, "_quiet"}, 32'(moved), 32'd0);
        step();
        check_eq({tag, "_stable"}, 32'(sw_stable), 32'(nxt));
        check_eq({tag, "_rise"}, 32'(sw_rise), 32'(rise));
        check_eq({tag, "_fall"}, 32'(sw_fall), 32'(fall));
        check_eq({tag, "_changed"}, 32'(sw_changed), 32'd1);
        step();
        check_eq({tag, "_clear"}, {27'd0, sw_rise, sw_changed}, 32'd0);
        check_eq({tag, "_fclear"}, 32'(sw_fall), 32'd0);
        check_eq({tag, "_hold"}, 32'(sw_stable), 32'(nxt));
    endtask

    initial begin
        bit moved;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sw_raw   = '0;
        repeat (3) step();
        check_eq("rst_stable", 32'(sw_stable), 32'd0);
        check_eq("rst_pulses", {23'd0, sw_rise, sw_fall, sw_changed}, 32'd0);

        // Switch held high through reset: seen as a fresh press after release.
        sw_raw = 4'hF;
        step();
        check_eq("rst_held_stable", 32'(sw_stable), 32'd0);
        rst = 1'b0;
        expect_accept("rst_rel", 4'h0, 4'hF, 4'hF, 4'h0);

        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_async_stable", 32'(sw_stable), 32'd0);
        check_eq("rst_async_changed", 32'(sw_changed), 32'd0);
        step();
        rst = 1'b0;
        expect_accept("rst_again", 4'h0, 4'hF, 4'hF, 4'h0);

`ifdef SW_DEBOUNCE_BYPASS_EN
        sw_raw = 4'h0;
        expect_accept("byp_clr", 4'hF, 4'h0, 4'h0, 4'hF);
        sw_raw = 4'h5;
        expect_accept("byp_set5", 4'h0, 4'h5, 4'h5, 4'h0);

        // One-cycle glitch on bit 1 passes through as a rise then a fall.
        sw_raw = 4'h7;
        step();
        sw_raw = 4'h5;
        step();
        check_eq("byp_gl_e1", 32'(sw_stable), 32'h5);
        step();
        check_eq("byp_gl_rise_stable", 32'(sw_stable), 32'h7);
        check_eq("byp_gl_rise", 32'(sw_rise), 32'h2);
        check_eq("byp_gl_rise_chg", 32'(sw_changed), 32'd1);
        step();
        check_eq("byp_gl_fall_stable", 32'(sw_stable), 32'h5);
        check_eq("byp_gl_fall", 32'(sw_fall), 32'h2);
        check_eq("byp_gl_fall_rise", 32'(sw_rise), 32'h0);
        step();
        check_eq("byp_gl_clear", {27'd0, sw_fall, sw_changed}, 32'd0);
`else
        // Reset in the middle of a count discards progress and emits nothing.
        sw_raw = 4'h0;
        expect_accept("all_off", 4'hF, 4'h0, 4'h0, 4'hF);
        sw_raw = 4'hA;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        sw_raw = 4'h0;
        watch_quiet(14, 4'h0, moved);
        check_eq("rst_midcount_quiet", 32'(moved), 32'd0);

        // Clean press and release of bit 1.
        sw_raw = 4'b0010;
        expect_accept("press", 4'h0, 4'h2, 4'h2, 4'h0);
        sw_raw = 4'b0000;
        expect_accept("release", 4'h2, 4'h0, 4'h0, 4'h2);

        // Bounce: high 5, low 2, then high for good.
        sw_raw = 4'b0001;
        watch_quiet(5, 4'h0, moved);
        check_eq("bounce_hi", 32'(moved), 32'd0);
        sw_raw = 4'b0000;
        watch_quiet(2, 4'h0, moved);
        check_eq("bounce_lo", 32'(moved), 32'd0);
        sw_raw = 4'b0001;
        expect_accept("bounce_acc", 4'h0, 4'h1, 4'h1, 4'h0);
        sw_raw = 4'b0000;
        expect_accept("bounce_clr", 4'h1, 4'h0, 4'h0, 4'h1);

        // Seven-cycle pulse on bit 3 is one short of acceptance.
        sw_raw = 4'b1000;
        watch_quiet(7, 4'h0, moved);
        sw_raw = 4'b0000;
        check_eq("glitch7_during", 32'(moved), 32'd0);
        watch_quiet(16, 4'h0, moved);
        check_eq("glitch7_after", 32'(moved), 32'd0);

        // Eight-cycle pulse is accepted at edge 9, then the fall 8 edges later.
        sw_raw = 4'b1000;
        repeat (8) step();
        sw_raw = 4'b0000;
        step();
        check_eq("pulse8_e8", {23'd0, sw_stable, sw_rise, sw_changed}, 32'd0);
        step();
        check_eq("pulse8_stable", 32'(sw_stable), 32'h8);
        check_eq("pulse8_rise", 32'(sw_rise), 32'h8);
        watch_quiet(7, 4'h8, moved);
        check_eq("pulse8_hold", 32'(moved), 32'd0);
        step();
        check_eq("pulse8_fall_stable", 32'(sw_stable), 32'h0);
        check_eq("pulse8_fall", 32'(sw_fall), 32'h8);
        check_eq("pulse8_fall_chg", 32'(sw_changed), 32'd1);
        step();
        check_eq("pulse8_fall_clear", {27'd0, sw_fall, sw_changed}, 32'd0);

        // Simultaneous: bits 0 and 2 rise while bit 3 falls.
        sw_raw = 4'b1000;
        expect_accept("simul_pre", 4'h0, 4'h8, 4'h8, 4'h0);
        sw_raw = 4'b0101;
        expect_accept("simul", 4'h8, 4'h5, 4'h5, 4'h8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
